// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants, FSM state type and digit helpers for the
//                sequential multi-word BCD adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

   localparam int C_DIGIT_W  = 4;                     // bits per BCD digit
   localparam int C_WORD_W   = 16;                    // bits per operand word
   localparam int C_NDIGITS  = C_WORD_W / C_DIGIT_W;  // digits per word
   localparam int C_BCD_CORR = 6;                     // decimal adjust value
   localparam int C_BCD_MAX  = 9;                     // largest legal digit

   // IDLE: next accepted word starts an operation; RUN: mid-operation
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Nine's complement of one digit (wraps for illegal digits, err flags those)
   function automatic logic [C_DIGIT_W-1:0] nines_comp(input logic [C_DIGIT_W-1:0] d);
      return C_DIGIT_W'(C_BCD_MAX) - d;
   endfunction

   // True when any nibble of the word is outside 0..9
   function automatic logic has_bad_digit(input logic [C_WORD_W-1:0] w);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < C_NDIGITS; i++) begin
         if (w[i*C_DIGIT_W +: C_DIGIT_W] > C_DIGIT_W'(C_BCD_MAX)) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_word_add.sv
// ============================================================================
//  Module      : bcd_word_add
//  Description : Combinational 4-digit packed BCD adder with decimal
//                carry-in and carry-out (digit ripple).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_word_add
   import bcd_pkg::*;
(
   input  logic [C_WORD_W-1:0] a,
   input  logic [C_WORD_W-1:0] b,
   input  logic                ci,
   output logic [C_WORD_W-1:0] s,
   output logic                co
);

   logic [C_NDIGITS:0] w_c;

   assign w_c[0] = ci;
   assign co     = w_c[C_NDIGITS];

   // One decimal digit per slice: binary add, then +6 and carry when above 9
   for (genvar gi = 0; gi < C_NDIGITS; gi++) begin : g_digit
      logic [C_DIGIT_W:0] w_t;
      logic [C_DIGIT_W:0] w_adj;
      logic               w_gt9;

      assign w_t   = {1'b0, a[gi*C_DIGIT_W +: C_DIGIT_W]}
                   + {1'b0, b[gi*C_DIGIT_W +: C_DIGIT_W]}
                   + {{C_DIGIT_W{1'b0}}, w_c[gi]};
      assign w_gt9 = (w_t > (C_DIGIT_W+1)'(C_BCD_MAX));
      assign w_adj = w_t + (C_DIGIT_W+1)'(C_BCD_CORR);
      assign s[gi*C_DIGIT_W +: C_DIGIT_W] = w_gt9 ? w_adj[C_DIGIT_W-1:0]
                                                  : w_t[C_DIGIT_W-1:0];
      assign w_c[gi+1] = w_gt9;
   end

endmodule

`default_nettype wire

// File: rtl/bcd_add_seq.sv
// ============================================================================
//  Module      : bcd_add_seq
//  Description : Sequential multi-word packed-BCD adder. Operands arrive one
//                16-bit word per handshake, LS word first; one result word is
//                produced per accepted word with a one-deep output register.
//                Optional macro BCD_ADD_SEQ_SUB_EN adds port op_sub
//                (nine's-complement subtraction).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add_seq
   import bcd_pkg::*;
#(
   parameter int NWORDS = 4
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [C_WORD_W-1:0] a,
   input  logic [C_WORD_W-1:0] b,
   input  logic                cin,
   input  logic                in_last,
`ifdef BCD_ADD_SEQ_SUB_EN
   input  logic                op_sub,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [C_WORD_W-1:0] sum,
   output logic                out_last,
   output logic                cout,
   output logic                err
);

   localparam int CW = $clog2(NWORDS);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic                  r_carry;
   logic                  r_err_acc;
   logic                  w_accept;
   logic                  w_first;
   logic                  w_last;
   logic                  w_ci;
   logic                  w_err_word;
   logic [C_WORD_W-1:0]   w_b_eff;
   logic [C_WORD_W-1:0]   w_s;
   logic                  w_co;

   assign in_ready   = !out_valid || out_ready;
   assign w_accept   = in_valid && in_ready;
   assign w_first    = (r_state == IDLE);
   assign w_last     = in_last || (r_cnt == CW'(NWORDS-1));
   assign w_err_word = has_bad_digit(a) || has_bad_digit(b) || (!w_first && r_err_acc);

`ifdef BCD_ADD_SEQ_SUB_EN
   logic r_sub;
   logic w_sub;

   assign w_sub = w_first ? op_sub : r_sub;
   assign w_ci  = w_first ? (op_sub ? 1'b1 : cin) : r_carry;

   // Subtrahend digits become their nine's complement when subtracting
   for (genvar gi = 0; gi < C_NDIGITS; gi++) begin : g_ninecomp
      assign w_b_eff[gi*C_DIGIT_W +: C_DIGIT_W] =
         w_sub ? nines_comp(b[gi*C_DIGIT_W +: C_DIGIT_W])
               : b[gi*C_DIGIT_W +: C_DIGIT_W];
   end

   // Latch the operation type on the first word and hold it for the rest
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      r_sub <= 1'b0;
      else if (w_accept && w_first) r_sub <= op_sub;
   end
`else
   assign w_ci    = w_first ? cin : r_carry;
   assign w_b_eff = b;
`endif

   bcd_word_add u_word_add (
      .a  (a),
      .b  (w_b_eff),
      .ci (w_ci),
      .s  (w_s),
      .co (w_co)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next state: any last word ends the operation, otherwise stay in RUN
   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) w_state_nxt = w_last ? IDLE : RUN;
   end

   // Word counter, inter-word carry/err and the one-deep output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_carry   <= 1'b0;
         r_err_acc <= 1'b0;
         out_valid <= 1'b0;
         sum       <= '0;
         out_last  <= 1'b0;
         cout      <= 1'b0;
         err       <= 1'b0;
      end else if (w_accept) begin
         r_cnt     <= w_last ? '0 : r_cnt + CW'(1);
         r_carry   <= w_co;
         r_err_acc <= w_err_word;
         out_valid <= 1'b1;
         sum       <= w_s;
         out_last  <= w_last;
         cout      <= w_last && w_co;
         err       <= w_last && w_err_word;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bcd_add_seq.sv
// ============================================================================
//  Module      : tb_bcd_add_seq
//  Description : Self-checking bench for bcd_add_seq with a digit-level
//                decimal reference model and an output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_add_seq;

   localparam int NWORDS = 4;

   typedef struct packed {
      logic [15:0] sum;
      logic        last;
      logic        cout;
      logic        err;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, cin, in_last;
   logic        out_valid, out_ready, out_last, cout, err;
   logic [15:0] a, b, sum;
`ifdef BCD_ADD_SEQ_SUB_EN
   logic        op_sub;
`endif

   res_t got_q[$];
   res_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   drv_done;

   // reference model state: position in operation, carry, err, subtract mode
   int   m_pos = 0;
   int   m_carry = 0;
   bit   m_err = 1'b0;
   bit   m_sub = 1'b0;

   bcd_add_seq #(.NWORDS(NWORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .in_last   (in_last),
`ifdef BCD_ADD_SEQ_SUB_EN
      .op_sub    (op_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .out_last  (out_last),
      .cout      (cout),
      .err       (err)
   );

   always #5 clk = ~clk;

   // record every result word transferred (sampled mid-cycle)
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) got_q.push_back('{sum, out_last, cout, err});
   end

   function automatic logic [15:0] rand_bcd();
      logic [15:0] w;
      for (int i = 0; i < 4; i++) w[i*4 +: 4] = 4'($urandom_range(0, 9));
      return w;
   endfunction

   function automatic void model_reset();
      m_pos = 0; m_carry = 0; m_err = 1'b0; m_sub = 1'b0;
   endfunction

   // decimal digit arithmetic on one accepted word
   function automatic void model_word(input logic [15:0] wa, input logic [15:0] wb,
                                      input logic wcin, input logic wlast, input logic wsub);
      int   c, da, db, t;
      bit   e, lst;
      logic [15:0] s;
      if (m_pos == 0) begin
         m_sub = wsub;
         c = m_sub ? 1 : int'(wcin);
         e = 1'b0;
      end else begin
         c = m_carry;
         e = m_err;
      end
      for (int d = 0; d < 4; d++) begin
         da = int'(wa[d*4 +: 4]);
         db = int'(wb[d*4 +: 4]);
         if (da > 9 || db > 9) e = 1'b1;
         if (m_sub) db = (9 - db) & 15;
         t = da + db + c;
         if (t > 9) begin
            s[d*4 +: 4] = 4'((t + 6) % 16);
            c = 1;
         end else begin
            s[d*4 +: 4] = 4'(t);
            c = 0;
         end
      end
      lst = wlast || (m_pos == NWORDS - 1);
      exp_q.push_back('{s, lst, lst ? c[0] : 1'b0, lst ? e : 1'b0});
      m_carry = c;
      m_err   = e;
      m_pos   = lst ? 0 : m_pos + 1;
   endfunction

   // present one word and hold it until accepted (bounded)
   task automatic drive_word(input logic [15:0] wa, input logic [15:0] wb,
                             input logic wcin, input logic wlast, input logic wsub);
      bit acc = 1'b0;
      int n = 0;
      in_valid = 1'b1; a = wa; b = wb; cin = wcin; in_last = wlast;
`ifdef BCD_ADD_SEQ_SUB_EN
      op_sub = wsub;
`endif
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
      end else begin
         model_word(wa, wb, wcin, wlast, wsub);
      end
   endtask

   task automatic wait_got(input int n, output bit ok);
      int k = 0;
      while (got_q.size() < n && k < 500) begin
         @(posedge clk);
         k++;
      end
      #1;
      ok = (got_q.size() >= n);
   endtask

   task automatic start_test();
      repeat (2) @(posedge clk);
      #1;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
`ifdef BCD_ADD_SEQ_SUB_EN
      op_sub = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checks++;
      if ({out_valid, sum, out_last, cout, err, in_ready} !== {1'b0, 16'h0000, 4'b0001}) begin
         errors++;
         $display("FAIL reset_state: got v=%b sum=%h last=%b cout=%b err=%b rdy=%b, required 0 0000 0 0 0 1",
                  out_valid, sum, out_last, cout, err, in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_single();
      start_test();
      drive_word(16'h1234, 16'h8766, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({out_valid, sum, out_last, cout, err} !== {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL single_word: got v=%b sum=%h last=%b cout=%b err=%b, required 1 0000 1 1 0",
                  out_valid, sum, out_last, cout, err);
      end
   endtask

   task automatic test_ripple();
      bit ok;
      start_test();
      for (int i = 0; i < 4; i++) drive_word(16'h9999, 16'h0000, 1'b1, i == 3, 1'b0);
      wait_got(4, ok);
      checks++;
      if (!ok || got_q[3] !== res_t'({16'h0000, 1'b1, 1'b1, 1'b0})) begin
         errors++;
         $display("FAIL ripple_last: got %0d words last=%h, required 0000 last=1 cout=1 err=0",
                  got_q.size(), ok ? got_q[3] : '0);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL ripple[%0d]: got %h, required %h", i,
                     (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
      end
   endtask

   task automatic test_forced_last();
      bit ok;
      start_test();
      for (int i = 0; i < 4; i++) drive_word(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      drive_word(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
      wait_got(5, ok);
      checks++;
      if (!ok || got_q[3].last !== 1'b1 || got_q[4].sum !== 16'h0001) begin
         errors++;
         $display("FAIL forced_last: got %0d words w3.last=%b w4.sum=%h, required last=1 sum=0001",
                  got_q.size(), ok ? got_q[3].last : 1'bx, ok ? got_q[4].sum : 16'hxxxx);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL forced[%0d]: got %h, required %h", i,
                     (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [19:0] hold;
      start_test();
      fork
         begin
            for (int i = 0; i < 8; i++)
               drive_word(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), i == 2 || i == 7, 1'b0);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            hold = {out_valid, sum, out_last, cout, err};
            for (int k = 0; k < 3; k++) begin
               if (k > 0) @(negedge clk);
               checks++;
               if (in_ready !== 1'b0 || {out_valid, sum, out_last, cout, err} !== hold || hold[19] !== 1'b1) begin
                  errors++;
                  $display("FAIL stall[%0d]: got rdy=%b out=%h, required rdy=0 out=%h valid", k,
                           in_ready, {out_valid, sum, out_last, cout, err}, hold);
               end
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_got(8, ok);
      repeat (3) @(posedge clk);
      checks++;
      if (got_q.size() != 8) begin
         errors++;
         $display("FAIL bp_count: got %0d words, required 8", got_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL bp[%0d]: got %h, required %h", i,
                     (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
      end
   endtask

   task automatic test_invalid_reset();
      bit ok;
      start_test();
      drive_word(16'h00A0, rand_bcd(), 1'b0, 1'b0, 1'b0);
      drive_word(rand_bcd(), rand_bcd(), 1'b0, 1'b1, 1'b0);
      wait_got(2, ok);
      checks++;
      if (!ok || got_q[0].err !== 1'b0 || got_q[1].err !== 1'b1 || got_q[1] !== exp_q[1]) begin
         errors++;
         $display("FAIL invalid_digit: got %0d words err0=%b last=%h, required err0=0 last=%h",
                  got_q.size(), ok ? got_q[0].err : 1'bx, ok ? got_q[1] : '0, exp_q[1]);
      end
      // partial operation, then reset mid-operation
      drive_word(16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0);
      drive_word(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
      wait_got(4, ok);
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, sum, out_last, cout, err, in_ready} !== {1'b0, 16'h0000, 4'b0001}) begin
         errors++;
         $display("FAIL mid_reset: got v=%b sum=%h last=%b cout=%b err=%b rdy=%b, required 0 0000 0 0 0 1",
                  out_valid, sum, out_last, cout, err, in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      got_q.delete();
      exp_q.delete();
      drive_word(16'h0005, 16'h0004, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({out_valid, sum, out_last, cout, err} !== {1'b1, 16'h0010, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL after_reset: got v=%b sum=%h last=%b cout=%b err=%b, required 1 0010 1 0 0",
                  out_valid, sum, out_last, cout, err);
      end
   endtask

   task automatic test_random();
      bit ok;
      int nw = 0;
      start_test();
      drv_done = 1'b0;
      fork
         begin
            for (int op = 0; op < 30; op++) begin
               int len = $urandom_range(1, NWORDS);
               for (int w = 0; w < len; w++) begin
                  logic [15:0] ra = ($urandom_range(0, 9) == 0) ? 16'($urandom()) : rand_bcd();
                  logic [15:0] rb = ($urandom_range(0, 9) == 0) ? 16'($urandom()) : rand_bcd();
                  logic        lst = (w == len - 1) ? (len == NWORDS ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
                  drive_word(ra, rb, 1'($urandom_range(0, 1)), lst, 1'b0);
                  nw++;
                  if ($urandom_range(0, 3) == 0) begin
                     @(posedge clk);
                     #1;
                  end
               end
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      wait_got(nw, ok);
      checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rand_count: got %0d words, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand[%0d]: got %h, required %h", i,
                     (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
      end
   endtask

`ifdef BCD_ADD_SEQ_SUB_EN
   task automatic test_sub();
      start_test();
      drive_word(16'h0100, 16'h0001, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({sum, out_last, cout} !== {16'h0099, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL sub_pos: got sum=%h last=%b cout=%b, required 0099 1 1", sum, out_last, cout);
      end
      drive_word(16'h0001, 16'h0002, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({sum, out_last, cout} !== {16'h9999, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sub_neg: got sum=%h last=%b cout=%b, required 9999 1 0", sum, out_last, cout);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_ripple();
      test_forced_last();
      test_backpressure();
      test_invalid_reset();
      test_random();
`ifdef BCD_ADD_SEQ_SUB_EN
      test_sub();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
